mmio_gpio: RTL and testbench
============================

// Module: mmio_gpio
// PURPOSE
//  - Parametrised memory-mapped GPIO peripheral on the proc core bus (realaddr/dout/W/din).
//  - Supersedes the single fixed-address LED latch with a register window at BASE_ADDR.
//  - Provides set/clear/readback outputs, synchronised inputs and a registered read path.
//  - Top-level muxes din from this block and from memory using rd_hit.
// PARAMETERS
//  ADDR_W     16       width of realaddr (word address)
//  DATA_W     32       bus data width
//  GPIO_W     10       number of output pins and number of input pins (1..DATA_W)
//  BASE_ADDR  16'h000F word address of register 0; the window is BASE_ADDR..BASE_ADDR+7
//  OUT_RST    0        reset value of the OUT register (GPIO_W bits)
// PORTS
//  clk       in   1        core clock; all state updates on the rising edge
//  reset     in   1        asynchronous, active-high reset
//  realaddr  in   ADDR_W   word address from the core
//  dout      in   DATA_W   write data from the core
//  W         in   1        write strobe; one write per asserted cycle
//  din       out  DATA_W   registered read data to the core
//  rd_hit    out  1        registered: din holds this block's data (address was in window)
//  gpio_out  out  GPIO_W   OUT register, drives pins/LEDs
//  gpio_in   in   GPIO_W   asynchronous external inputs
//  irq       out  1        level interrupt, |(EDGE & IRQ_MASK)
// BEHAVIOUR
//  - Reset (async, active-high): gpio_out=OUT_RST, din=0, rd_hit=0, sync flops=0, EDGE=0, IRQ_MASK=0, irq=0.
//  - Register map (offset = realaddr-BASE_ADDR):
//    0 OUT RW | 1 SET W1S | 2 CLR W1C | 3 IN RO | 4 EDGE RW1C | 5 IRQ_MASK RW | 6,7 reserved (read 0).
//  - Writes (W=1, address in window) take effect at the next edge:
//    OUT<=dout[GPIO_W-1:0]; SET: OUT|=dout; CLR: OUT&=~dout.
//  - Writes to IN, reserved offsets or addresses outside the window: no effect.
//  - Read: on every edge din<=reg[offset] (zero-extended to DATA_W), rd_hit<=in-window.
//    Out of window: din<=0, rd_hit<=0. Latency is 1 cycle, matching memory. Reads ignore W.
//  - A read and a write to the same register in one cycle return the pre-write value.
//  - gpio_in passes through a 2-flop synchroniser; IN = sync stage 2 (2-cycle latency).
//  - Out of window = realaddr<BASE_ADDR or realaddr>BASE_ADDR+7, compared at ADDR_W width.
//    BASE_ADDR+7 must not exceed 2^ADDR_W-1 (no wrap).
//  - Bits above GPIO_W in dout are ignored; read bits above GPIO_W are 0.
// CONFIGURATION
//  - Macro MMIO_GPIO_EDGE_EN.
//  - Defined:
//    - A third sync flop is added. EDGE[i] sets on a rising edge of the synchronised input
//      (stage2=1 & stage3=0), one cycle after IN updates.
//    - Writing 1 to an EDGE bit clears it. In the same cycle, a new edge wins: the bit stays 1.
//    - IRQ_MASK is RW. irq is registered: irq <= |(EDGE_next & IRQ_MASK_next).
//  - Not defined:
//    - No edge logic. EDGE and IRQ_MASK read 0 and writes to them are ignored. irq tied 0.
// TESTING
//  1. Assert reset mid-run with OUT=0x155 -> gpio_out=0 immediately (async), din=0, rd_hit=0.
//  2. Write OUT=0x0AA, SET 0x300, CLR 0x00A -> gpio_out 0x0AA, 0x3AA, 0x3A0 on successive cycles.
//  3. Read BASE+0 -> din=0x000003A0, rd_hit=1 one cycle later.
//     Read 0x0000 -> din=0, rd_hit=0. Read BASE+6 -> din=0, rd_hit=1.
//  4. gpio_in 0x000->0x201 -> IN reads 0x201 from 2 edges after the change, never earlier.
//  5. (EDGE_EN) Write IRQ_MASK=0x001; raise gpio_in[0] -> EDGE=0x001 and irq=1.
//     Write EDGE=0x001 -> irq=0. Repeat the clear in the same cycle as a new edge -> EDGE stays 0x001.
//  6. (no EDGE_EN) Same stimulus as 5 -> EDGE/IRQ_MASK read 0 and irq stays 0.

Source files
------------

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO window at BASE_ADDR: OUT/SET/CLR/IN/EDGE/IRQ_MASK, 1-cycle registered reads.
// Define MMIO_GPIO_EDGE_EN to add rising-edge capture, IRQ mask and a registered level interrupt.
module mmio_gpio #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       GPIO_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h000F,
  parameter logic [GPIO_W-1:0] OUT_RST   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] realaddr,
  input  logic [DATA_W-1:0] dout,
  input  logic              W,
  output logic [DATA_W-1:0] din,
  output logic              rd_hit,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(7);

  logic              w_hit, w_wr;
  logic [ADDR_W-1:0] w_off;
  logic [2:0]        w_sel;
  logic [GPIO_W-1:0] w_wdat, w_out_nxt, w_rsel, w_edge, w_mask;
  logic [GPIO_W-1:0] r_out, r_sync1, r_sync2;
  logic              w_unused;

  assign w_hit    = (realaddr >= BASE_ADDR) && (realaddr <= LAST_ADDR);
  assign w_off    = realaddr - BASE_ADDR;
  assign w_sel    = w_off[2:0];
  assign w_wdat   = dout[GPIO_W-1:0];
  assign w_wr     = W && w_hit;
  assign gpio_out = r_out;
  // upper data bits and upper offset bits are don't-care by design
  assign w_unused = ^{dout, w_off};

  always_comb begin
    w_out_nxt = r_out;
    if (w_wr) begin
      case (w_sel)
        3'd0:    w_out_nxt = w_wdat;
        3'd1:    w_out_nxt = r_out | w_wdat;
        3'd2:    w_out_nxt = r_out & ~w_wdat;
        default: w_out_nxt = r_out;
      endcase
    end
  end

  // read mux sees pre-write state, so a same-cycle read returns the old value
  always_comb begin
    w_rsel = '0;
    case (w_sel)
      3'd0:    w_rsel = r_out;
      3'd3:    w_rsel = r_sync2;
      3'd4:    w_rsel = w_edge;
      3'd5:    w_rsel = w_mask;
      default: w_rsel = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= OUT_RST;
      r_sync1 <= '0;
      r_sync2 <= '0;
      din     <= '0;
      rd_hit  <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      din     <= w_hit ? DATA_W'(w_rsel) : '0;
      rd_hit  <= w_hit;
    end
  end

`ifdef MMIO_GPIO_EDGE_EN
  logic [GPIO_W-1:0] r_sync3, r_edge, r_mask;
  logic [GPIO_W-1:0] w_rise, w_clr, w_edge_nxt, w_mask_nxt;
  logic              r_irq;

  // a fresh rising edge overrides a same-cycle W1C clear
  always_comb begin
    w_rise     = r_sync2 & ~r_sync3;
    w_clr      = (w_wr && (w_sel == 3'd4)) ? w_wdat : '0;
    w_edge_nxt = (r_edge & ~w_clr) | w_rise;
    w_mask_nxt = (w_wr && (w_sel == 3'd5)) ? w_wdat : r_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync3 <= '0;
      r_edge  <= '0;
      r_mask  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_sync3 <= r_sync2;
      r_edge  <= w_edge_nxt;
      r_mask  <= w_mask_nxt;
      r_irq   <= |(w_edge_nxt & w_mask_nxt);
    end
  end

  assign w_edge = r_edge;
  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_edge = '0;
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed + randomized bench for mmio_gpio against a register-level reference model.
module tb_mmio_gpio;
  localparam logic [15:0] BASE = 16'h000F;
`ifdef MMIO_GPIO_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] realaddr;
  logic [31:0] dout;
  logic        W;
  logic [31:0] din;
  logic        rd_hit;
  logic [9:0]  gpio_out;
  logic [9:0]  gpio_in;
  logic        irq;

  always #5 clk = ~clk;

  mmio_gpio #(
    .ADDR_W(16), .DATA_W(32), .GPIO_W(10), .BASE_ADDR(BASE), .OUT_RST(10'h000)
  ) dut (
    .clk(clk), .reset(reset), .realaddr(realaddr), .dout(dout), .W(W),
    .din(din), .rd_hit(rd_hit), .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  // model: architectural registers plus history of sampled pin values (q[0] newest)
  logic [9:0] m_out, m_edge, m_mask;
  logic       m_irq;
  logic [9:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out  = 10'h000;
    m_edge = 10'h000;
    m_mask = 10'h000;
    m_irq  = 1'b0;
    q.delete();
    repeat (3) q.push_back(10'h000);
  endtask

  function automatic logic [9:0] mread(input int off);
    case (off)
      0:       return m_out;
      3:       return q[1];
      4:       return m_edge;
      5:       return m_mask;
      default: return 10'h000;
    endcase
  endfunction

  task automatic cyc(input int addr, input logic [31:0] d, input logic we,
                     input logic [9:0] gin, input string tag);
    bit          hit;
    int          off;
    logic [31:0] e_din;
    logic [9:0]  rise, dw;
    realaddr = addr[15:0];
    dout     = d;
    W        = we;
    gpio_in  = gin;
    hit   = (addr >= int'(BASE)) && (addr <= int'(BASE) + 7);
    off   = addr - int'(BASE);
    e_din = hit ? {22'h0, mread(off)} : 32'h0;
    rise  = q[1] & ~q[2];
    dw    = d[9:0];
    if (we && hit) begin
      case (off)
        0: m_out = dw;
        1: m_out = m_out | dw;
        2: m_out = m_out & ~dw;
        4: if (EDGE_EN) m_edge = m_edge & ~dw;
        5: if (EDGE_EN) m_mask = dw;
        default: ;
      endcase
    end
    if (EDGE_EN) m_edge = m_edge | rise;
    m_irq = EDGE_EN && (|(m_edge & m_mask));
    q.push_front(gin);
    void'(q.pop_back());
    @(posedge clk);
    #1;
    chk({tag, ".din"}, din, e_din);
    chk({tag, ".rd_hit"}, {31'h0, rd_hit}, {31'h0, hit});
    chk({tag, ".gpio_out"}, {22'h0, gpio_out}, {22'h0, m_out});
    chk({tag, ".irq"}, {31'h0, irq}, {31'h0, m_irq});
  endtask

  initial begin
    int          a;
    logic [9:0]  g;
    reset    = 1'b1;
    realaddr = 16'h0;
    dout     = 32'h0;
    W        = 1'b0;
    gpio_in  = 10'h000;
    model_reset();
    #2;
    chk("rst.gpio_out", {22'h0, gpio_out}, 32'h0);
    chk("rst.din", din, 32'h0);
    chk("rst.rd_hit", {31'h0, rd_hit}, 32'h0);
    chk("rst.irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // OUT / SET / CLR
    cyc(BASE + 0, 32'h0000_00AA, 1'b1, 10'h000, "wr_out");
    chk("wr_out.const", {22'h0, gpio_out}, 32'h0AA);
    cyc(BASE + 1, 32'hFFFF_F300, 1'b1, 10'h000, "wr_set");
    chk("wr_set.const", {22'h0, gpio_out}, 32'h3AA);
    cyc(BASE + 2, 32'h0000_000A, 1'b1, 10'h000, "wr_clr");
    chk("wr_clr.const", {22'h0, gpio_out}, 32'h3A0);

    // read path
    cyc(BASE + 0, 32'h0, 1'b0, 10'h000, "rd_out");
    chk("rd_out.const", din, 32'h0000_03A0);
    cyc(0, 32'h0, 1'b0, 10'h000, "rd_zero");
    chk("rd_zero.hit", {31'h0, rd_hit}, 32'h0);
    cyc(BASE + 6, 32'h0, 1'b0, 10'h000, "rd_rsv");
    chk("rd_rsv.hit", {31'h0, rd_hit}, 32'h1);
    cyc(BASE + 8, 32'h0, 1'b1, 10'h000, "wr_past");
    cyc(BASE - 1, 32'h0, 1'b1, 10'h000, "wr_below");
    chk("oow.gpio_out", {22'h0, gpio_out}, 32'h3A0);

    // input synchroniser latency
    cyc(BASE + 3, 32'h0, 1'b0, 10'h201, "in_e1");
    chk("in_e1.const", din, 32'h0);
    cyc(BASE + 3, 32'h0, 1'b0, 10'h201, "in_e2");
    chk("in_e2.const", din, 32'h0);
    cyc(BASE + 3, 32'h0, 1'b0, 10'h201, "in_e3");
    chk("in_e3.const", din, 32'h201);

    // edge capture / interrupt
    repeat (4) cyc(BASE + 4, 32'h0, 1'b0, 10'h000, "settle");
    cyc(BASE + 4, 32'h3FF, 1'b1, 10'h000, "edge_clr_all");
    cyc(BASE + 5, 32'h001, 1'b1, 10'h000, "mask_wr");
    repeat (4) cyc(BASE + 4, 32'h0, 1'b0, 10'h001, "rise0");
    chk("rise0.edge", din, EDGE_EN ? 32'h1 : 32'h0);
    chk("rise0.irq", {31'h0, irq}, EDGE_EN ? 32'h1 : 32'h0);
    cyc(BASE + 4, 32'h001, 1'b1, 10'h001, "edge_w1c");
    chk("edge_w1c.irq", {31'h0, irq}, 32'h0);
    cyc(BASE + 5, 32'h0, 1'b0, 10'h001, "mask_rd");
    chk("mask_rd.const", din, EDGE_EN ? 32'h1 : 32'h0);
    repeat (3) cyc(0, 32'h0, 1'b0, 10'h000, "fall0");
    cyc(0, 32'h0, 1'b0, 10'h001, "rerise1");
    cyc(0, 32'h0, 1'b0, 10'h001, "rerise2");
    cyc(BASE + 4, 32'h001, 1'b1, 10'h001, "clr_vs_edge");
    chk("clr_vs_edge.irq", {31'h0, irq}, EDGE_EN ? 32'h1 : 32'h0);
    cyc(BASE + 4, 32'h0, 1'b0, 10'h001, "clr_vs_edge_rd");
    chk("clr_vs_edge.edge", din, EDGE_EN ? 32'h1 : 32'h0);

    // randomized traffic
    g = 10'h000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) a = int'($urandom_range(0, 65535));
      else a = int'(BASE) - 2 + int'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) g = 10'($urandom);
      cyc(a, $urandom, 1'($urandom_range(0, 1)), g, "rnd");
    end

    // asynchronous reset mid-run
    cyc(BASE + 0, 32'h155, 1'b1, g, "pre_rst");
    chk("pre_rst.const", {22'h0, gpio_out}, 32'h155);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.gpio_out", {22'h0, gpio_out}, 32'h0);
    chk("arst.din", din, 32'h0);
    chk("arst.rd_hit", {31'h0, rd_hit}, 32'h0);
    chk("arst.irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold.gpio_out", {22'h0, gpio_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc(BASE + 0, 32'h0, 1'b0, 10'h000, "post_rst");
    cyc(BASE + 3, 32'h0, 1'b0, 10'h000, "post_rst_in");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
